fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DW, default 8: data width, matches FIFO data_in.
REQ-002 Parameter DEPTH, default 8: FIFO capacity in words.
REQ-003 Parameter BURST_MAX, default 4: max consecutive transfers per ownership while the other requester waits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req0, req1  input  1 each  requester valid; data held stable until accepted.
REQ-007 data0, data1  input  DW each  requester write data.
REQ-008 gnt0, gnt1  output  1 each  ready to requester; combinational from registered state, fifo_cnt and fifo_wr.
REQ-009 fifo_cnt  input  4  occupancy from FIFO.
REQ-010 fifo_wr  output  1  registered FIFO write strobe.
REQ-011 fifo_din  output  DW  registered FIFO write data.
REQ-012 owner  output  2  registered state code: 00 IDLE, 01 OWN0, 10 OWN1.

Function
REQ-013 can_write SHALL be (fifo_cnt + fifo_wr) < DEPTH, computed at 5-bit width so no wrap.
REQ-014 gnt0 SHALL be (state==OWN0) & can_write; gnt1 SHALL be (state==OWN1) & can_write; both never high together.
REQ-015 Transfer on requester x SHALL occur at a rising edge where req_x & gnt_x.
REQ-016 On a transfer, fifo_wr SHALL be 1 and fifo_din SHALL equal data_x in the next cycle (latency 1); otherwise fifo_wr SHALL be 0 and fifo_din SHALL hold its value.
REQ-017 IDLE: no grants; if req0 or req1 is high, next state SHALL be OWN of the winner; otherwise stay IDLE.
REQ-018 Winner when both request SHALL be the requester not served last (rr flag); rr flag SHALL update to the owner on every entry to OWN0/OWN1.
REQ-019 burst_cnt (width holds 0..BURST_MAX) SHALL clear on any state change and increment on each transfer.
REQ-020 OWNx with req_x low: next SHALL be OWN of the other if its req is high, else IDLE.
REQ-021 OWNx with a transfer making burst_cnt reach BURST_MAX: next SHALL be OWN of the other if its req is high; else stay OWNx with burst_cnt cleared.
REQ-022 OWNx with req_x high and can_write low: state and burst_cnt SHALL hold (stall); no transfer.
REQ-023 Full boundary: with fifo_cnt==DEPTH-1 and fifo_wr==1, can_write SHALL be 0; no FIFO overflow may be caused under any input sequence.
REQ-024 FIFO reads lowering fifo_cnt SHALL re-enable grants in the same cycle fifo_cnt drops.

Reset
REQ-025 While rst==0: state IDLE, owner 00, gnt0=gnt1=0, fifo_wr=0, fifo_din=0, burst_cnt=0, rr flag=1 (requester 0 wins first tie).
REQ-026 Reset assertion mid-burst SHALL take effect immediately, abandoning any in-flight transfer; first grant after release no earlier than 1 cycle after a request is seen in IDLE.

Verification
REQ-027 Reset release, req0=1 data0=8'hA5, fifo_cnt=0 -> cycle1 owner=01, gnt0=1; cycle2 fifo_wr=1, fifo_din=8'hA5.
REQ-028 req0=req1=1 continuously, fifo_cnt=0, BURST_MAX=4 -> 4 writes from requester0, ownership switch, 4 from requester1, alternating; no cycle with both gnts high.
REQ-029 req1 only, fifo_cnt=7, fifo_wr=1 in flight -> gnt1=0; fifo_cnt falls to 6 with fifo_wr=0 -> gnt1=1 same cycle.
REQ-030 Single requester req0 held for 10 transfers, req1=0 -> 10 back-to-back writes, owner stays 01, burst_cnt wraps at 4.
REQ-031 rst driven low during OWN1 with transfer pending -> outputs to reset values asynchronously, no fifo_wr pulse after reset.
REQ-032 req0 dropped mid-burst with req1=1 -> next cycle owner=10, burst_cnt=0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter for a single FIFO write port: round-robin ownership,
// a per-ownership burst limit, and back-pressure from the FIFO occupancy count.
module fifo_wr_arb #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic [3:0]    fifo_cnt,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_din,
    output logic [1:0]    owner
);
    localparam int            BW         = $clog2(BURST_MAX + 1);
    localparam logic [4:0]    DEPTH_W    = 5'(DEPTH);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state;
    logic          rr;
    logic [BW-1:0] burst_cnt;
    logic          can_write;
    logic          xfer0;
    logic          xfer1;

    // A write already on the strobe has not reached fifo_cnt yet, so count it too.
    assign can_write = ({1'b0, fifo_cnt} + {4'b0000, fifo_wr}) < DEPTH_W;
    assign gnt0      = (state == OWN0) && can_write;
    assign gnt1      = (state == OWN1) && can_write;
    assign xfer0     = req0 && gnt0;
    assign xfer1     = req1 && gnt1;
    assign owner     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr        <= 1'b1;
            burst_cnt <= '0;
            fifo_wr   <= 1'b0;
            fifo_din  <= '0;
        end else begin
            fifo_wr <= xfer0 || xfer1;
            if (xfer0)
                fifo_din <= data0;
            else if (xfer1)
                fifo_din <= data1;

            case (state)
                IDLE: begin
                    // rr set means requester 1 was served last, so requester 0 wins a tie.
                    if (req0 && (!req1 || rr)) begin
                        state     <= OWN0;
                        rr        <= 1'b0;
                        burst_cnt <= '0;
                    end else if (req1) begin
                        state     <= OWN1;
                        rr        <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        burst_cnt <= '0;
                        if (req1) begin
                            state <= OWN1;
                            rr    <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer0) begin
                        if (burst_cnt == BURST_LAST) begin
                            burst_cnt <= '0;
                            if (req1) begin
                                state <= OWN1;
                                rr    <= 1'b1;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        burst_cnt <= '0;
                        if (req0) begin
                            state <= OWN0;
                            rr    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer1) begin
                        if (burst_cnt == BURST_LAST) begin
                            burst_cnt <= '0;
                            if (req0) begin
                                state <= OWN0;
                                rr    <= 1'b0;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: expected write data is queued as stimulus is
// planned and popped whenever the arbiter strobes fifo_wr.
module tb_fifo_wr_arb;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic [3:0]    fifo_cnt = '0;
    logic          gnt0, gnt1, fifo_wr;
    logic [DW-1:0] fifo_din;
    logic [1:0]    owner;

    int unsigned   n_checks = 0;
    int unsigned   n_pass = 0;
    int unsigned   n0 = 0, n1 = 0;
    int unsigned   cyc = 0;
    logic          hs0, hs1;
    logic [DW-1:0] exp_q[$];

    fifo_wr_arb #(.DW(DW), .DEPTH(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .fifo_cnt(fifo_cnt),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample handshakes before the edge, score the write after it,
    // then let each requester advance to its next word once accepted.
    task automatic cycle();
        @(negedge clk);
        hs0 = req0 & gnt0;
        hs1 = req1 & gnt1;
        check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_wr) begin
            if (exp_q.size() == 0) check("spurious_wr", 32'(fifo_wr), 32'd0);
            else check("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
        end
        if (hs0) begin
            n0--;
            data0 = data0 + 8'd1;
            if (n0 == 0) req0 = 1'b0;
        end
        if (hs1) begin
            n1--;
            data1 = data1 + 8'd1;
            if (n1 == 0) req1 = 1'b0;
        end
    endtask

    task automatic run_drain(input int unsigned budget);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; n0 = 0; n1 = 0; fifo_cnt = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_wr;
        int last_wr;

        // Reset state, with a request already asserted
        req0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_wr", 32'(fifo_wr), 32'd0);
        check("rst_din", 32'(fifo_din), 32'd0);

        // First transfer after release
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; data0 = 8'hA5; n0 = 1;
        exp_q.push_back(8'hA5);
        #1;
        check("idle_no_gnt", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1;
        check("c1_owner", 32'(owner), 32'd1);
        check("c1_gnt0", 32'(gnt0), 32'd1);
        check("c1_wr", 32'(fifo_wr), 32'd0);
        cycle();
        check("c2_wr", 32'(fifo_wr), 32'd1);
        run_drain(4);

        // Both requesting: bursts of four alternate, requester 0 first
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + 4 * b + i));
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h20 + 4 * b + i));
        end
        req0 = 1'b1; n0 = 8; data0 = 8'h10;
        req1 = 1'b1; n1 = 8; data1 = 8'h20;
        run_drain(40);

        // Lone requester keeps ownership across burst wraps, back to back
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h40 + i));
        req0 = 1'b1; n0 = 10; data0 = 8'h40;
        first_wr = -1; last_wr = -1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            cycle();
            if (fifo_wr) begin
                if (first_wr < 0) first_wr = int'(cyc);
                last_wr = int'(cyc);
                check("solo_owner", 32'(owner), 32'd1);
            end
        end
        check("solo_span", 32'(last_wr - first_wr), 32'd9);
        run_drain(4);

        // Full boundary and same-cycle re-enable on a FIFO read
        do_reset();
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        fifo_cnt = 4'd6; req1 = 1'b1; n1 = 2; data1 = 8'h60;
        cycle();
        check("f_owner", 32'(owner), 32'd2);
        check("f_gnt1_open", 32'(gnt1), 32'd1);
        cycle();
        check("f_wr_inflight", 32'(fifo_wr), 32'd1);
        fifo_cnt = 4'd7;
        #1;
        check("f_gnt1_cnt7_wr", 32'(gnt1), 32'd0);
        cycle();
        check("f_no_overflow", 32'(fifo_wr), 32'd0);
        fifo_cnt = 4'd8;
        #1;
        check("f_gnt1_full", 32'(gnt1), 32'd0);
        cycle();
        check("f_stall_owner", 32'(owner), 32'd2);
        check("f_stall_wr", 32'(fifo_wr), 32'd0);
        fifo_cnt = 4'd6;
        #1;
        check("f_gnt1_reopen", 32'(gnt1), 32'd1);
        run_drain(6);

        // Owner drops mid-burst with the other waiting
        do_reset();
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h80);
        req0 = 1'b1; n0 = 2; data0 = 8'h70;
        req1 = 1'b1; n1 = 1; data1 = 8'h80;
        repeat (3) cycle();
        check("drop_owner_before", 32'(owner), 32'd1);
        cycle();
        check("drop_owner_after", 32'(owner), 32'd2);
        check("drop_wr_gap", 32'(fifo_wr), 32'd0);
        run_drain(6);

        // Asynchronous reset during OWN1 with another transfer pending
        do_reset();
        exp_q.push_back(8'h90);
        req1 = 1'b1; n1 = 3; data1 = 8'h90;
        cycle();
        cycle();
        check("ar_wr_before", 32'(fifo_wr), 32'd1);
        check("ar_pending", 32'(gnt1 & req1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_owner", 32'(owner), 32'd0);
        check("ar_gnt1", 32'(gnt1), 32'd0);
        check("ar_wr", 32'(fifo_wr), 32'd0);
        check("ar_din", 32'(fifo_din), 32'd0);
        req1 = 1'b0; n1 = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("ar_hold_wr", 32'(fifo_wr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("ar_post_wr", 32'(fifo_wr), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
